// File: rtl/sar_conv_sequencer.sv
// Sequencer for a successive-approximation ADC: a requestable sample phase, then an
// MSB-first binary search, with the finished code held behind a valid/ready handshake.
module sar_conv_sequencer #(
  parameter int NBITS  = 6,
  parameter int SLEN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic [SLEN_W-1:0] sample_len,
  input  logic              comp_in,
  output logic              sample,
  output logic              comp_en,
  output logic [NBITS-1:0]  dac_code,
  output logic              busy,
  output logic [NBITS-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              overrun
);

  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONVERT
  } state_t;

  state_t            state_q, state_d;
  logic [SLEN_W-1:0] cnt_q, cnt_d;
  logic [NBITS-1:0]  acc_q, acc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NBITS-1:0]  result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              overrun_q, overrun_d;

  logic [SLEN_W-1:0] slen_eff;
  logic [NBITS-1:0]  bit_mask;
  logic [NBITS-1:0]  acc_upd;
  logic              complete;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overrun_d      = overrun_q;
    complete       = 1'b0;

    // A zero sample length still gets one sampling cycle.
    slen_eff = (sample_len == '0) ? SLEN_W'(1) : sample_len;
    bit_mask = {{(NBITS-1){1'b0}}, 1'b1} << idx_q;
    acc_upd  = (acc_q & ~bit_mask) | (comp_in ? bit_mask : '0);

    case (state_q)
      S_IDLE: begin
        if (start || cont) begin
          cnt_d   = slen_eff;
          acc_d   = '0;
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (cnt_q <= SLEN_W'(1)) begin
          idx_d   = IW'(NBITS - 1);
          state_d = S_CONVERT;
        end else begin
          cnt_d = cnt_q - SLEN_W'(1);
        end
      end
      S_CONVERT: begin
        acc_d = acc_upd;
        idx_d = idx_q - IW'(1);
        if (idx_q == '0) begin
          complete = 1'b1;
          result_d = acc_upd;
          acc_d    = '0;
          if (cont) begin
            cnt_d   = slen_eff;
            state_d = S_SAMPLE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A completion wins over a same-edge consume; only an unconsumed overwrite is flagged.
    if (complete) begin
      result_valid_d = 1'b1;
      if (result_valid_q && !result_ready) overrun_d = 1'b1;
    end else if (result_valid_q && result_ready) begin
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      acc_q          <= '0;
      idx_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      idx_q          <= idx_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign sample       = (state_q == S_SAMPLE);
  assign comp_en      = (state_q == S_CONVERT);
  assign busy         = (state_q != S_IDLE);
  assign dac_code     = (state_q == S_CONVERT) ? (acc_q | bit_mask) : '0;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overrun      = overrun_q;

endmodule
